mem_stage: RTL

Memory-access stage of the five-stage pipeline, between the EX/MEM register and `mem_wb`. It issues loads and stores to the data memory over a ready/valid request-response interface and aligns, sign-extends and packs the data. It produces the write-back address/data pair that `mem_wb` latches every cycle, and stalls the front of the pipeline while an access is outstanding.

---
 rtl/mem_stage_pkg.sv | 17 +
 rtl/mem_load_align.sv | 20 ++
 rtl/mem_stage.sv | 69 ++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared width, size/state encodings and store-packing helpers for the memory stage
package mem_stage_pkg;
  localparam int W = 32;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return size == 2'b11 || (size == SZ_H && lo[0]) || (size == SZ_W && lo != 2'b00);
  endfunction
  function automatic logic [W-1:0] pack_wdata(input logic [1:0] size, input logic [W-1:0] d);
    return size == SZ_B ? {4{d[7:0]}} : size == SZ_H ? {2{d[15:0]}} : d;
  endfunction
  function automatic logic [3:0] pack_wstrb(input logic [1:0] size, input logic [1:0] lo);
    return size == SZ_B ? 4'b0001 << lo : size == SZ_H ? 4'b0011 << (lo & 2'b10) : 4'b1111;
  endfunction
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: selects the load lane from rdata and sign/zero-extends it
//   rdata: raw memory word, addr_lo: byte offset, size: access size,
//   uns: zero-extend, data: aligned register value
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [W-1:0] rdata,
  input  logic [1:0]   addr_lo,
  input  logic [1:0]   size,
  input  logic         uns,
  output logic [W-1:0] data
);
  logic [W-1:0] lane;
  // aligned accesses only reach here, so a single byte-granular shift covers byte and half lanes
  always_comb begin
    lane = rdata >> {addr_lo, 3'b000};
    data = size == SZ_B ? {{24{~uns & lane[7]}}, lane[7:0]} :
           size == SZ_H ? {{16{~uns & lane[15]}}, lane[15:0]} : lane;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage issuing ready/valid data-memory accesses and producing write-back
//   ex_*: instruction from EX/MEM, dmem_*: data-memory request/response,
//   mem_stall: hold upstream, mem_misaligned: alignment fault, mem_write_back_*/mem_valid: to mem_wb
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         ex_valid,
  input  logic         ex_load,
  input  logic         ex_store,
  input  logic [1:0]   ex_size,
  input  logic         ex_unsigned,
  input  logic [W-1:0] ex_addr,
  input  logic [W-1:0] ex_store_data,
  input  logic [4:0]   ex_rd,
  input  logic [W-1:0] ex_alu_result,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [W-1:0] dmem_addr,
  output logic [W-1:0] dmem_wdata,
  output logic [3:0]   dmem_wstrb,
  input  logic         dmem_ready,
  input  logic         dmem_rvalid,
  input  logic [W-1:0] dmem_rdata,
  output logic         mem_stall,
  output logic         mem_misaligned,
  output logic [4:0]   mem_write_back_addr,
  output logic [W-1:0] mem_write_back_data,
  output logic         mem_valid
);
  state_e state_q, state_d;
  logic mem_op, misal, go, alu, ld;
  logic [W-1:0] load_data;
  mem_load_align u_align (
    .rdata(dmem_rdata),
    .addr_lo(ex_addr[1:0]),
    .size(ex_size),
    .uns(ex_unsigned),
    .data(load_data)
  );
  assign mem_op = ex_valid & (ex_load | ex_store);
  assign misal  = misaligned(ex_size, ex_addr[1:0]);
  assign go     = (state_q == S_IDLE && mem_op && !misal) || state_q == S_REQ;
  assign alu    = state_q == S_IDLE && ex_valid && !ex_load && !ex_store;
  assign ld     = state_q == S_WAIT && dmem_rvalid;
  always_ff @(posedge sys_clk or negedge sys_rst)
    if (!sys_rst) state_q <= S_IDLE;
    else state_q <= state_d;
  // ex_store wins when both op bits are set, so a store never waits for a response
  always_comb begin
    state_d = state_q;
    if (go) state_d = !dmem_ready ? S_REQ : ex_store ? S_IDLE : S_WAIT;
    else if (ld) state_d = S_IDLE;
  end
  // outputs are forced to zero while reset is held, even with a live instruction upstream
  always_comb begin
    dmem_req            = sys_rst & go;
    dmem_we             = sys_rst & go & ex_store;
    dmem_addr           = dmem_req ? {ex_addr[W-1:2], 2'b00} : '0;
    dmem_wdata          = dmem_we ? pack_wdata(ex_size, ex_store_data) : '0;
    dmem_wstrb          = dmem_we ? pack_wstrb(ex_size, ex_addr[1:0]) : '0;
    mem_stall           = sys_rst & (go ? !(dmem_ready && ex_store) : state_q == S_WAIT && !dmem_rvalid);
    mem_misaligned      = sys_rst & state_q == S_IDLE & mem_op & misal;
    mem_valid           = sys_rst & (alu | ld);
    mem_write_back_addr = mem_valid ? ex_rd : '0;
    mem_write_back_data = !mem_valid ? '0 : alu ? ex_alu_result : load_data;
  end
endmodule
